// File: rtl/overlay_pkg.sv
// Shared widths, draw-mode encoding and distance helper for the marker overlay.
package overlay_pkg;
   localparam int COORD_W = 11;
   localparam int PIX_W   = 24;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_LINES = 2'd1,
      MODE_CROSS = 2'd2,
      MODE_BOX   = 2'd3
   } mode_e;

   // One extra bit keeps the signed difference of two unsigned coordinates exact.
   function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
      logic signed [COORD_W:0] d;
      logic [COORD_W:0]        r;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      r = d[COORD_W] ? -d : d;
      return r;
   endfunction
endpackage

// File: rtl/marker_overlay_if.sv
// Pixel-rate video bundle: data enable, syncs and one RGB pixel per clock.
interface marker_overlay_if;
   import overlay_pkg::*;

   logic             de;
   logic             h_sync;
   logic             v_sync;
   logic [PIX_W-1:0] pixel;

   modport master (output de, h_sync, v_sync, pixel);
   modport slave  (input  de, h_sync, v_sync, pixel);
endinterface

// File: rtl/marker_hit.sv
// Combinational hit test of one pixel position against one marker shape.
// Zero latency; no backpressure (pure function of its inputs).
module marker_hit
   import overlay_pkg::*;
#(
   parameter int HALF_T = 0,
   parameter int ARM    = 8,
   parameter int BOX    = 8
) (
   input  logic [COORD_W-1:0] pos_x_i,
   input  logic [COORD_W-1:0] pos_y_i,
   input  logic [COORD_W-1:0] center_x_i,
   input  logic [COORD_W-1:0] center_y_i,
   input  logic               enable_i,
   input  mode_e              mode_i,
   output logic               hit_o
);
   localparam int DW = COORD_W + 1;
   localparam logic [DW-1:0] HT    = DW'(HALF_T);
   localparam logic [DW-1:0] AR    = DW'(ARM);
   localparam logic [DW-1:0] BX    = DW'(BOX);
   localparam logic [DW-1:0] BX_IN = DW'(BOX - HALF_T);

   logic [DW-1:0] dx;
   logic [DW-1:0] dy;

   assign dx = abs_diff(pos_x_i, center_x_i);
   assign dy = abs_diff(pos_y_i, center_y_i);

   always_comb begin
      hit_o = 1'b0;
      if (enable_i) begin
         case (mode_i)
            MODE_LINES: hit_o = (dx <= HT) || (dy <= HT);
            MODE_CROSS: hit_o = ((dx <= HT) && (dy <= AR)) || ((dy <= HT) && (dx <= AR));
            // Outline only: inside the outer square but on or beyond the inner edge.
            MODE_BOX:   hit_o = (dx <= BX) && (dy <= BX) && ((dx >= BX_IN) || (dy >= BX_IN));
            default:    hit_o = 1'b0;
         endcase
      end
   end
endmodule

// File: rtl/marker_overlay.sv
// Overlays N_MARK frame-latched markers onto an RGB video stream.
// Latency 2 clk fixed for pixel and syncs; no backpressure (pixel-rate stream).
module marker_overlay
   import overlay_pkg::*;
#(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int N_MARK = 2,
   parameter int HALF_T = 0,
   parameter int ARM    = 8,
   parameter int BOX    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   marker_overlay_if.slave           vid_i,
   marker_overlay_if.master          vid_o,
   input  logic [COORD_W*N_MARK-1:0] x_center_i,
   input  logic [COORD_W*N_MARK-1:0] y_center_i,
   input  logic [N_MARK-1:0]         mark_en_i,
   input  logic [PIX_W*N_MARK-1:0]   mark_color_i,
   input  logic [1:0]                mode_i,
   output logic                      frame_start_o
);
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

   logic [COORD_W-1:0]        x_pos_q, x_pos_d;
   logic [COORD_W-1:0]        y_pos_q, y_pos_d;
   logic                      vs_prev_q, fs_q;
   logic                      latch;
   logic [COORD_W*N_MARK-1:0] xc_q, yc_q;
   logic [N_MARK-1:0]         en_q;
   logic [PIX_W*N_MARK-1:0]   col_q;
   mode_e                     mode_q;
   logic [N_MARK-1:0]         hit_d, hit1_q;
   logic                      de1_q, hs1_q, vs1_q;
   logic [PIX_W-1:0]          pix1_q;
   logic                      de2_q, hs2_q, vs2_q;
   logic [PIX_W-1:0]          pix2_q, pix2_d;

   assign latch = vid_i.v_sync & ~vs_prev_q;

   // Vsync dominates, so de asserted during vsync never advances the raster.
   always_comb begin
      x_pos_d = x_pos_q;
      y_pos_d = y_pos_q;
      if (vid_i.v_sync) begin
         x_pos_d = '0;
         y_pos_d = '0;
      end else if (vid_i.de) begin
         if (x_pos_q == X_LAST) begin
            x_pos_d = '0;
            y_pos_d = (y_pos_q == Y_LAST) ? '0 : y_pos_q + 1'b1;
         end else begin
            x_pos_d = x_pos_q + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < N_MARK; k++) begin : g_mark
      marker_hit #(
         .HALF_T (HALF_T),
         .ARM    (ARM),
         .BOX    (BOX)
      ) u_hit (
         .pos_x_i    (x_pos_q),
         .pos_y_i    (y_pos_q),
         .center_x_i (xc_q[k*COORD_W +: COORD_W]),
         .center_y_i (yc_q[k*COORD_W +: COORD_W]),
         .enable_i   (en_q[k]),
         .mode_i     (mode_q),
         .hit_o      (hit_d[k])
      );
   end

   // Scan from the top so the lowest-index hit is the last (winning) assignment.
   always_comb begin
      pix2_d = pix1_q;
      for (int k = N_MARK - 1; k >= 0; k--) begin
         if (hit1_q[k]) pix2_d = col_q[k*PIX_W +: PIX_W];
      end
      if (!de1_q) pix2_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_pos_q   <= '0;
         y_pos_q   <= '0;
         vs_prev_q <= 1'b0;
         fs_q      <= 1'b0;
         xc_q      <= '0;
         yc_q      <= '0;
         en_q      <= '0;
         col_q     <= '0;
         mode_q    <= MODE_PASS;
         hit1_q    <= '0;
         de1_q     <= 1'b0;
         hs1_q     <= 1'b0;
         vs1_q     <= 1'b0;
         pix1_q    <= '0;
         de2_q     <= 1'b0;
         hs2_q     <= 1'b0;
         vs2_q     <= 1'b0;
         pix2_q    <= '0;
      end else begin
         x_pos_q   <= x_pos_d;
         y_pos_q   <= y_pos_d;
         vs_prev_q <= vid_i.v_sync;
         fs_q      <= latch;
         if (latch) begin
            xc_q   <= x_center_i;
            yc_q   <= y_center_i;
            en_q   <= mark_en_i;
            col_q  <= mark_color_i;
            mode_q <= mode_e'(mode_i);
         end
         hit1_q <= hit_d;
         de1_q  <= vid_i.de;
         hs1_q  <= vid_i.h_sync;
         vs1_q  <= vid_i.v_sync;
         pix1_q <= vid_i.pixel;
         de2_q  <= de1_q;
         hs2_q  <= hs1_q;
         vs2_q  <= vs1_q;
         pix2_q <= pix2_d;
      end
   end

   assign vid_o.de       = de2_q;
   assign vid_o.h_sync   = hs2_q;
   assign vid_o.v_sync   = vs2_q;
   assign vid_o.pixel    = pix2_q;
   assign frame_start_o  = fs_q;
endmodule

// File: tb/tb_marker_overlay.sv
// Scoreboard bench: two overlays (HALF_T 0 and 1) share one stimulus stream;
// expected pixels are queued at issue time and popped by a negedge monitor.
module tb_marker_overlay;
   import overlay_pkg::*;

   localparam int W  = 64;
   localparam int H  = 64;
   localparam int NM = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   marker_overlay_if vin ();
   marker_overlay_if vout0 ();
   marker_overlay_if vout1 ();

   logic [COORD_W*NM-1:0] x_center, y_center;
   logic [NM-1:0]         mark_en;
   logic [PIX_W*NM-1:0]   mark_color;
   logic [1:0]            mode;
   logic                  fs0, fs1;

   marker_overlay #(.IMG_W(W), .IMG_H(H), .N_MARK(NM), .HALF_T(0), .ARM(8), .BOX(8)) dut0 (
      .clk(clk), .rst(rst), .vid_i(vin), .vid_o(vout0),
      .x_center_i(x_center), .y_center_i(y_center), .mark_en_i(mark_en),
      .mark_color_i(mark_color), .mode_i(mode), .frame_start_o(fs0));

   marker_overlay #(.IMG_W(W), .IMG_H(H), .N_MARK(NM), .HALF_T(1), .ARM(8), .BOX(8)) dut1 (
      .clk(clk), .rst(rst), .vid_i(vin), .vid_o(vout1),
      .x_center_i(x_center), .y_center_i(y_center), .mark_en_i(mark_en),
      .mark_color_i(mark_color), .mode_i(mode), .frame_start_o(fs1));

   typedef struct {
      logic [23:0] pix;
      bit          probe;
      logic [23:0] ppix;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   pr_f[$], pr_d[$], pr_x[$], pr_y[$];
   logic [23:0] pr_v[$];

   int n_cmp = 0;
   int n_err = 0;
   int n_vs = 0;
   int fs_cnt0 = 0;
   int fs_cnt1 = 0;
   bit done = 0;

   // Reference state captured by the bench at each vsync it issues.
   int          lat_mode;
   int          lat_x[NM], lat_y[NM];
   bit [NM-1:0] lat_en;
   logic [23:0] lat_col[NM];

   // Input history {de,hs,vs}: h2 is what the outputs should show now.
   logic [2:0] h1, h2;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         h1 <= '0;
         h2 <= '0;
      end else begin
         h1 <= {vin.de, vin.h_sync, vin.v_sync};
         h2 <= h1;
      end
   end

   function automatic bit in_rng(int v, int c, int r);
      return (v >= c - r) && (v <= c + r);
   endfunction

   function automatic bit model_hit(int x, int y, int cx, int cy, int ht, int m);
      case (m)
         1: return in_rng(x, cx, ht) || in_rng(y, cy, ht);
         2: return (in_rng(x, cx, ht) && in_rng(y, cy, 8)) || (in_rng(y, cy, ht) && in_rng(x, cx, 8));
         3: return in_rng(x, cx, 8) && in_rng(y, cy, 8) &&
                   !(in_rng(x, cx, 7 - ht) && in_rng(y, cy, 7 - ht));
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [23:0] exp_pix(int ht, int x, int y, logic [23:0] pin);
      for (int k = 0; k < NM; k++)
         if (lat_en[k] && model_hit(x, y, lat_x[k], lat_y[k], ht, lat_mode)) return lat_col[k];
      return pin;
   endfunction

   task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h, want %h (t=%0t)", nm, d, act, exp, $time);
      end
   endtask

   task automatic mon(int d, logic de, logic hs, logic vs, logic fs, logic [23:0] pix);
      exp_t e;
      int   sz;
      chk("de_dly", d, 32'(de), 32'(h2[2]));
      chk("hs_dly", d, 32'(hs), 32'(h2[1]));
      chk("vs_dly", d, 32'(vs), 32'(h2[0]));
      chk("frame_start", d, 32'(fs), 32'(h1[0] & ~h2[0]));
      if (de) begin
         sz = (d == 0) ? q0.size() : q1.size();
         if (sz == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_pixel dut%0d: de_out high, pixel %h, none expected", d, pix);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("pixel", d, 32'(pix), 32'(e.pix));
            if (e.probe) chk("probe", d, 32'(pix), 32'(e.ppix));
         end
      end else begin
         chk("blank_black", d, 32'(pix), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         chk("fs_count", 0, 32'(fs_cnt0), 32'(n_vs));
         chk("fs_count", 1, 32'(fs_cnt1), 32'(n_vs));
         chk("q_drained", 0, 32'(q0.size()), 32'd0);
         chk("q_drained", 1, 32'(q1.size()), 32'd0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end else begin
         if (rst) begin
            chk("rst_outputs", 0, {4'd0, vout0.de, vout0.h_sync, vout0.v_sync, fs0, vout0.pixel}, 32'd0);
            chk("rst_outputs", 1, {4'd0, vout1.de, vout1.h_sync, vout1.v_sync, fs1, vout1.pixel}, 32'd0);
         end
         if (fs0) fs_cnt0++;
         if (fs1) fs_cnt1++;
         mon(0, vout0.de, vout0.h_sync, vout0.v_sync, fs0, vout0.pixel);
         mon(1, vout1.de, vout1.h_sync, vout1.v_sync, fs1, vout1.pixel);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic drive(bit de, bit hs, bit vs, logic [23:0] p);
      vin.de = de;
      vin.h_sync = hs;
      vin.v_sync = vs;
      vin.pixel = p;
      @(posedge clk);
      #1;
   endtask

   task automatic add_probe(int f, int d, int x, int y, logic [23:0] v);
      pr_f.push_back(f); pr_d.push_back(d); pr_x.push_back(x); pr_y.push_back(y); pr_v.push_back(v);
   endtask

   task automatic set_cfg(int md, int x0, int y0, int x1, int y1, logic [1:0] en,
                          logic [23:0] c0, logic [23:0] c1);
      mode = 2'(md);
      x_center = {11'(x1), 11'(x0)};
      y_center = {11'(y1), 11'(y0)};
      mark_en = en;
      mark_color = {c1, c0};
   endtask

   task automatic clear_model();
      lat_mode = 0;
      lat_en = '0;
      for (int k = 0; k < NM; k++) begin
         lat_x[k] = 0; lat_y[k] = 0; lat_col[k] = '0;
      end
   endtask

   task automatic push(int fid, int x, int y, logic [23:0] p);
      exp_t e0, e1;
      e0.pix = exp_pix(0, x, y, p); e0.probe = 0; e0.ppix = '0;
      e1.pix = exp_pix(1, x, y, p); e1.probe = 0; e1.ppix = '0;
      for (int i = 0; i < pr_f.size(); i++) begin
         if (pr_f[i] == fid && pr_x[i] == x && pr_y[i] == y) begin
            if (pr_d[i] == 0) begin e0.probe = 1; e0.ppix = pr_v[i]; end
            else              begin e1.probe = 1; e1.ppix = pr_v[i]; end
         end
      end
      q0.push_back(e0);
      q1.push_back(e1);
   endtask

   task automatic run_line(int fid, int y, int npix);
      logic [23:0] p;
      for (int x = 0; x < npix; x++) begin
         p = {8'(x), 8'(y), 8'hA5};
         push(fid, x, y, p);
         drive(1, 0, 0, p);
      end
   endtask

   task automatic run_frame(int fid, int chg_line, int chg_x);
      lat_mode = int'(mode);
      lat_en = mark_en;
      for (int k = 0; k < NM; k++) begin
         lat_x[k] = int'(x_center[k*COORD_W +: COORD_W]);
         lat_y[k] = int'(y_center[k*COORD_W +: COORD_W]);
         lat_col[k] = mark_color[k*PIX_W +: PIX_W];
      end
      n_vs++;
      repeat (3) drive(0, 0, 1, '0);
      repeat (2) drive(0, 0, 0, '0);
      for (int y = 0; y < H; y++) begin
         if (y == chg_line) x_center[COORD_W-1:0] = 11'(chg_x);
         run_line(fid, y, W);
         repeat (2) drive(0, 1, 0, '0);
         repeat (2) drive(0, 0, 0, '0);
      end
   endtask

   initial begin
      // Hand-computed probes: input pixel at (x,y) is {x, y, A5}.
      add_probe(0, 0, 5, 0, 24'h0500A5);
      add_probe(0, 1, 63, 0, 24'h3F00A5);
      add_probe(1, 0, 10, 5, 24'hFF0000);
      add_probe(1, 0, 3, 20, 24'hFF0000);
      add_probe(1, 0, 11, 21, 24'h0B15A5);
      add_probe(1, 1, 11, 21, 24'hFF0000);
      add_probe(1, 1, 12, 22, 24'h0C16A5);
      add_probe(2, 1, 40, 33, 24'hFF0000);
      add_probe(2, 1, 41, 32, 24'h2920A5);
      add_probe(2, 1, 33, 24, 24'hFF0000);
      add_probe(2, 0, 40, 33, 24'h2821A5);
      add_probe(2, 0, 32, 40, 24'hFF0000);
      add_probe(3, 0, 8, 0, 24'h00FF00);
      add_probe(3, 0, 8, 8, 24'h00FF00);
      add_probe(3, 0, 3, 8, 24'h00FF00);
      add_probe(3, 0, 63, 0, 24'h3F00A5);
      add_probe(3, 0, 0, 63, 24'h003FA5);
      add_probe(3, 0, 4, 4, 24'h0404A5);
      add_probe(3, 0, 9, 0, 24'h0900A5);
      add_probe(3, 1, 7, 3, 24'h00FF00);
      add_probe(4, 0, 16, 16, 24'hFF0000);
      add_probe(4, 0, 16, 40, 24'hFF0000);
      add_probe(4, 0, 40, 40, 24'h2828A5);
      add_probe(5, 0, 16, 16, 24'h00FF00);
      add_probe(6, 0, 10, 50, 24'hFF0000);
      add_probe(6, 0, 30, 50, 24'h1E32A5);
      add_probe(6, 0, 30, 20, 24'hFF0000);
      add_probe(7, 0, 30, 50, 24'hFF0000);
      add_probe(7, 0, 10, 50, 24'h0A32A5);

      rst = 1'b1;
      clear_model();
      set_cfg(1, 10, 20, 5, 5, 2'b11, 24'hFF0000, 24'h00FF00);
      repeat (3) drive(0, 0, 0, '0);
      rst = 1'b0;
      repeat (2) drive(0, 0, 0, '0);
      run_line(0, 0, W);
      repeat (4) drive(0, 0, 0, '0);
      run_line(0, 0, 20);
      // Reset mid-line: pixels still in flight are discarded.
      rst = 1'b1;
      q0.delete();
      q1.delete();
      clear_model();
      repeat (3) drive(0, 0, 0, '0);
      rst = 1'b0;
      repeat (2) drive(0, 0, 0, '0);
      run_line(0, 0, W);
      repeat (4) drive(0, 0, 0, '0);

      set_cfg(1, 10, 20, 40, 40, 2'b01, 24'hFF0000, 24'h00FF00);
      run_frame(1, -1, 0);
      set_cfg(2, 32, 32, 40, 40, 2'b01, 24'hFF0000, 24'h00FF00);
      run_frame(2, -1, 0);
      set_cfg(3, 32, 32, 0, 0, 2'b10, 24'hFF0000, 24'h00FF00);
      run_frame(3, -1, 0);
      set_cfg(1, 16, 16, 16, 16, 2'b11, 24'hFF0000, 24'h00FF00);
      run_frame(4, -1, 0);
      set_cfg(1, 16, 16, 16, 16, 2'b10, 24'hFF0000, 24'h00FF00);
      run_frame(5, -1, 0);
      set_cfg(1, 10, 20, 40, 40, 2'b01, 24'hFF0000, 24'h00FF00);
      run_frame(6, 32, 30);
      run_frame(7, -1, 0);
      repeat (6) drive(0, 0, 0, '0);
      done = 1'b1;
   end
endmodule
